// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encoding, FSM states and helpers for the HI/LO multiply/divide front-end
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DIV_START, ST_DIV_RUN, ST_MUL_RUN} mdu_state_e;
  localparam int DIV_LATENCY = 34;
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn & v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_hilo_ctrl_mul_seq.sv
// mdu_mul_seq: MUL_ITER-step shift-add multiplier on operand magnitudes, sign restored on output
module mdu_mul_seq
  import mdu_pkg::*;
#(
  parameter int MUL_ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [63:0] product_o
);
  localparam int CW = $clog2(MUL_ITER + 1);
  logic [63:0] acc, mcand;
  logic [31:0] mplier;
  logic [CW-1:0] cnt;
  logic neg, run;
  assign done_o = run & (cnt == '0);
  assign product_o = neg ? -acc : acc;
  // load magnitudes on start, then add-and-shift one multiplier bit per cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      neg <= 1'b0;
      run <= 1'b0;
    end else if (start_i) begin
      acc <= '0;
      mcand <= {32'd0, mag32(a_i, signed_i)};
      mplier <= mag32(b_i, signed_i);
      cnt <= CW'(MUL_ITER);
      neg <= signed_i & (a_i[31] ^ b_i[31]);
      run <= 1'b1;
    end else if (cnt != '0) begin
      acc <= acc + (mplier[0] ? mcand : 64'd0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: HI/LO owner and MULT/DIV sequencer in front of the Divider; MDU_DIV0_FAST_EN enables the divide-by-zero shortcut
module mdu_hilo_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        op_valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        kill_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] mf_data_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic        div_signed_o,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i
);
  mdu_state_e state;
  mdu_op_e op;
  logic accept, mul_start, mul_done, div_first, div_done, div0_fast;
  logic [63:0] mul_product;
  assign op = mdu_op_e'(op_i);
  assign busy_o = state != ST_IDLE;
  assign stall_o = op_valid_i & busy_o;
  assign accept = op_valid_i & ~stall_o;
  assign mul_start = accept & (op == OP_MULT | op == OP_MULTU);
  assign div_done = ~div_first & div_ready_i & ~div_busy_i;
  assign div_start_o = (state == ST_DIV_START) & ~kill_i;
  assign mf_data_o = !accept ? '0 : op == OP_MFHI ? hi_o : op == OP_MFLO ? lo_o : '0;
`ifdef MDU_DIV0_FAST_EN
  assign div0_fast = rt_i == '0;
`else
  assign div0_fast = 1'b0;
`endif
  mdu_mul_seq #(.MUL_ITER(MUL_ITER)) u_mul (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .start_i(mul_start),
    .signed_i(op == OP_MULT),
    .a_i(rs_i),
    .b_i(rt_i),
    .done_o(mul_done),
    .product_o(mul_product)
  );
  // sequencer: accepts ops in IDLE, tracks the running op, writes HI/LO on completion, kill wins over completion
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      hi_o <= '0;
      lo_o <= '0;
      div_dividend_o <= '0;
      div_divisor_o <= '0;
      div_signed_o <= 1'b0;
      div_first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          case (op)
            OP_MTHI: hi_o <= rs_i;
            OP_MTLO: lo_o <= rs_i;
            OP_MULT, OP_MULTU: state <= ST_MUL_RUN;
            OP_DIV, OP_DIVU: if (div0_fast) begin
              hi_o <= rs_i;
              lo_o <= '1;
            end else begin
              div_dividend_o <= rs_i;
              div_divisor_o <= rt_i;
              div_signed_o <= op == OP_DIV;
              state <= ST_DIV_START;
            end
            default: ;
          endcase
        end
        ST_DIV_START: begin
          state <= kill_i ? ST_IDLE : ST_DIV_RUN;
          div_first <= 1'b1;
        end
        ST_DIV_RUN: begin
          div_first <= 1'b0;
          if (kill_i) state <= ST_IDLE;
          else if (div_done) begin
            lo_o <= div_quotient_i;
            hi_o <= div_remainder_i;
            state <= ST_IDLE;
          end
        end
        ST_MUL_RUN: begin
          if (kill_i) state <= ST_IDLE;
          else if (mul_done) begin
            {hi_o, lo_o} <= mul_product;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
